mips_boot_loader: RTL and testbench

//  Upstream of SingleCycleMIPS: owns its reset and instruction-memory write port at power-up.

---
 rtl/mips_boot_loader_pkg.sv | 29 ++
 rtl/mips_boot_loader_word_packer.sv | 62 ++++++
 rtl/mips_boot_loader.sv | 172 +++++++++++++++++
 tb/tb_mips_boot_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_boot_loader_pkg.sv
// Shared definitions for the MIPS boot loader: loader states, header and
// datapath widths, parameter defaults and the word-address helper.
package mips_boot_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 16;   // LEN_HI:LEN_LO header, in words

    // Byte address of program word 0; also the CPU PC reset value.
    localparam logic [ADDR_W-1:0] BASE_ADDR_DEFAULT = 32'h0000_0000;
    localparam int unsigned       DEPTH_DEFAULT     = 256;

    typedef enum logic [2:0] {
        LD_LEN_HI = 3'd0,
        LD_LEN_LO = 3'd1,
        LD_DATA   = 3'd2,
        LD_CSUM   = 3'd3,
        LD_RUN    = 3'd4,
        LD_ERR    = 3'd5
    } ld_state_e;

    // Byte address of a word index; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/mips_boot_loader_word_packer.sv
// mips_word_packer: assembles four bytes MSB-first into a 32-bit word and
// keeps a running XOR of every byte taken in.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   byte_in/byte_en  data byte and its take-in strobe
//   clear            restart assembly and checksum (start of an image)
//   word             assembled word, valid together with word_valid (combinational)
//   word_valid       high while the 4th byte of a word is being taken in
//   csum             running XOR of all bytes taken since clear/reset (registered)
module mips_word_packer
    import mips_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_en,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic [BYTE_W-1:0] csum
);

    logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
    logic [1:0]               cnt_q,   cnt_d;
    logic [BYTE_W-1:0]        csum_q,  csum_d;

    // The 4th byte completes the word in the same cycle it arrives, so the
    // loader can register the write strobe on the following edge.
    assign word       = {shift_q, byte_in};
    assign word_valid = byte_en && (cnt_q == 2'd3);
    assign csum       = csum_q;

    // Next-state: clear wins over a byte so a new image always starts clean.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
            csum_d  = '0;
        end else if (byte_en) begin
            shift_d = {shift_q[WORD_W-2*BYTE_W-1:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
            csum_d  = csum_q ^ byte_in;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: receives a length-prefixed, XOR-checksummed byte image,
// writes it into instruction memory and holds the CPU in reset until the
// image verifies. A bad or oversize image leaves the CPU held forever.
// Ports:
//   clk, reset            clock, asynchronous active-high reset (restarts loading)
//   rx_data/rx_valid      incoming image byte and its valid
//   rx_ready              loader accepts a byte (registered)
//   imem_we/addr/wdata    one-cycle instruction-memory write port (registered)
//   cpu_reset             CPU reset, released only after verification
//   done                  image verified, CPU running
//   error                 sticky: checksum mismatch or length > DEPTH
module mips_boot_loader
    import mips_boot_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int unsigned       DEPTH     = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

    ld_state_e         state_q, state_d;
    logic [BYTE_W-1:0] len_hi_q, len_hi_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept_c;
    logic              pk_en_c;
    logic              pk_clr_c;
    logic [WORD_W-1:0] pk_word;
    logic              pk_word_valid;
    logic [BYTE_W-1:0] pk_csum;
    logic [LEN_W-1:0]  n_c;
    logic              last_word_c;

    assign accept_c = rx_valid && rx_ready_q;
    // Packer controls kept outside the FSM block so word_valid does not
    // feed back into the process that produces byte_en.
    assign pk_en_c  = accept_c && (state_q == LD_DATA);
    assign pk_clr_c = accept_c && (state_q == LD_LEN_HI);
    assign n_c      = {len_hi_q, rx_data};
    assign last_word_c = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

    mips_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (rx_data),
        .byte_en    (pk_en_c),
        .clear      (pk_clr_c),
        .word       (pk_word),
        .word_valid (pk_word_valid),
        .csum       (pk_csum)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        idx_d        = idx_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        unique case (state_q)
            LD_LEN_HI: begin
                if (accept_c) begin
                    len_hi_d = rx_data;
                    state_d  = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (accept_c) begin
                    len_d = n_c;
                    idx_d = '0;
                    if (32'(n_c) > 32'(DEPTH)) begin
                        state_d = LD_ERR;
                    end else if (n_c == '0) begin
                        state_d = LD_CSUM;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (pk_word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_addr(BASE_ADDR, ADDR_W'(idx_q));
                    imem_wdata_d = pk_word;
                    idx_d        = idx_q + IDX_W'(1);
                    if (last_word_c) begin
                        state_d = LD_CSUM;
                    end
                end
            end
            LD_CSUM: begin
                if (accept_c) begin
                    state_d = (rx_data == pk_csum) ? LD_RUN : LD_ERR;
                end
            end
            LD_RUN, LD_ERR: begin
                // Terminal until reset.
            end
            default: begin
                state_d = LD_ERR;
            end
        endcase

        // Status outputs follow the next state so they are registered and
        // change in the cycle right after the deciding byte is accepted.
        rx_ready_d  = (state_d != LD_RUN) && (state_d != LD_ERR);
        cpu_reset_d = (state_d != LD_RUN);
        done_d      = (state_d == LD_RUN);
        error_d     = (state_d == LD_ERR);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LD_LEN_HI;
            len_hi_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Bench for mips_boot_loader: two instances (DEPTH=256/BASE=0 and
// DEPTH=4/BASE=0x400), a per-instance write scoreboard fed by an image-level
// reference model, and status checks after each image.
module tb_mips_boot_loader;

    logic        clk;
    logic        reset    [2];
    logic [7:0]  rx_data  [2];
    logic        rx_valid [2];
    logic        rx_ready [2];
    logic        imem_we  [2];
    logic [31:0] imem_addr  [2];
    logic [31:0] imem_wdata [2];
    logic        cpu_reset [2];
    logic        done     [2];
    logic        error    [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    logic [7:0]  img[$];
    bit          tog = 0;

    mips_boot_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH(256)) u_dut0 (
        .clk(clk), .reset(reset[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .rx_ready(rx_ready[0]), .imem_we(imem_we[0]), .imem_addr(imem_addr[0]),
        .imem_wdata(imem_wdata[0]), .cpu_reset(cpu_reset[0]), .done(done[0]), .error(error[0])
    );

    mips_boot_loader #(.BASE_ADDR(32'h0000_0400), .DEPTH(4)) u_dut1 (
        .clk(clk), .reset(reset[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .rx_ready(rx_ready[1]), .imem_we(imem_we[1]), .imem_addr(imem_addr[1]),
        .imem_wdata(imem_wdata[1]), .cpu_reset(cpu_reset[1]), .done(done[1]), .error(error[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Write monitors: every strobe must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (!reset[0] && imem_we[0]) begin
            if (exp_q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut0 unexpected write: got addr %0h data %0h expected none",
                         imem_addr[0], imem_wdata[0]);
            end else begin
                chk("dut0 write", {imem_addr[0], imem_wdata[0]}, exp_q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset[1] && imem_we[1]) begin
            if (exp_q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut1 unexpected write: got addr %0h data %0h expected none",
                         imem_addr[1], imem_wdata[1]);
            end else begin
                chk("dut1 write", {imem_addr[1], imem_wdata[1]}, exp_q1.pop_front());
            end
        end
    end

    function automatic int qsize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic check_reset_vals(input int i, input logic [31:0] base);
        chk("rst rx_ready",   64'(rx_ready[i]),  64'd0);
        chk("rst imem_we",    64'(imem_we[i]),   64'd0);
        chk("rst imem_addr",  64'(imem_addr[i]), 64'(base));
        chk("rst imem_wdata", 64'(imem_wdata[i]), 64'd0);
        chk("rst cpu_reset",  64'(cpu_reset[i]), 64'd1);
        chk("rst done",       64'(done[i]),      64'd0);
        chk("rst error",      64'(error[i]),     64'd0);
    endtask

    task automatic pulse_reset(input int i);
        @(negedge clk);
        rx_valid[i] = 1'b0;
        #2 reset[i] = 1'b1;
        #1;
        chk("reset cpu_reset", 64'(cpu_reset[i]), 64'd1);
        chk("reset done",      64'(done[i]),      64'd0);
        chk("reset rx_ready",  64'(rx_ready[i]),  64'd0);
        @(negedge clk);
        reset[i] = 1'b0;
        @(negedge clk);
    endtask

    // mode: 0 no stalls, 1 rx_valid toggles each cycle, 2 random stalls.
    task automatic send_byte(input int i, input logic [7:0] b, input int mode);
        bit acc;
        bit stall;
        int guard;
        acc = 0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            tog = ~tog;
            stall = (mode == 1) ? tog : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (stall) begin
                rx_valid[i] = 1'b0;
            end else begin
                rx_valid[i] = 1'b1;
                rx_data[i]  = b;
                acc = rx_ready[i];
            end
            @(posedge clk);
            guard++;
        end
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL dut%0d byte accept timeout: got no accept expected accept", i);
        end
    endtask

    // Reference model: parse img by the image-format rules, queue the
    // expected writes, drive it and check the final status.
    task automatic run_image(input int i, input int mode);
        int          depth;
        logic [31:0] base;
        int          n;
        int          nsend;
        bit          oversize;
        bit          good;
        logic [7:0]  x;
        int          g;
        depth = (i == 0) ? 256 : 4;
        base  = (i == 0) ? 32'h0 : 32'h400;
        pulse_reset(i);
        n = {img[0], img[1]};
        oversize = (n > depth);
        good = 1'b0;
        nsend = 2;
        if (!oversize) begin
            x = 8'h00;
            for (int k = 0; k < n; k++) begin
                logic [31:0] w;
                w = {img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]};
                x = x ^ img[2+4*k] ^ img[3+4*k] ^ img[4+4*k] ^ img[5+4*k];
                if (i == 0) exp_q0.push_back({base + 32'(4*k), w});
                else        exp_q1.push_back({base + 32'(4*k), w});
            end
            good  = (img[2+4*n] == x);
            nsend = 3 + 4*n;
        end
        for (int j = 0; j < nsend; j++) send_byte(i, img[j], mode);
        @(negedge clk);
        rx_valid[i] = 1'b0;
        chk("status done",      64'(done[i]),      64'(good));
        chk("status error",     64'(error[i]),     64'(!good));
        chk("status cpu_reset", 64'(cpu_reset[i]), 64'(!good));
        chk("status rx_ready",  64'(rx_ready[i]),  64'd0);
        // Bytes offered in a terminal state must be ignored.
        rx_valid[i] = 1'b1;
        rx_data[i]  = 8'hA5;
        repeat (3) @(negedge clk);
        rx_valid[i] = 1'b0;
        chk("terminal rx_ready", 64'(rx_ready[i]), 64'd0);
        chk("terminal done",     64'(done[i]),     64'(good));
        g = 0;
        while (qsize(i) != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("writes drained", 64'(qsize(i)), 64'd0);
    endtask

    task automatic build_random(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        x = 8'h00;
        for (int k = 0; k < 4*n; k++) begin
            b = 8'($urandom);
            x = x ^ b;
            img.push_back(b);
        end
        img.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
    endtask

    task automatic load_list(input logic [7:0] l[]);
        img.delete();
        foreach (l[k]) img.push_back(l[k]);
    endtask

    initial begin
        logic [7:0] t1[];
        t1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            rx_valid[i] = 1'b0;
            rx_data[i] = 8'h00;
        end
        #1;
        check_reset_vals(0, 32'h0);
        check_reset_vals(1, 32'h400);
        #20;
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Good image, N=2.
        load_list(t1);
        run_image(0, 0);
        // Bad checksum.
        t1[10] = 8'h0F;
        load_list(t1);
        run_image(0, 0);
        t1[10] = 8'h0E;
        // Empty image.
        load_list('{8'h00, 8'h00, 8'h00});
        run_image(0, 0);
        // Toggled stalls.
        load_list(t1);
        run_image(0, 1);
        // Mid-load reset after the 6th byte: only word 0 may be written.
        pulse_reset(0);
        exp_q0.push_back({32'h0, 32'h2008_0005});
        for (int j = 0; j < 6; j++) send_byte(0, t1[j], 0);
        @(negedge clk);
        rx_valid[0] = 1'b0;
        #2 reset[0] = 1'b1;
        #1;
        chk("midreset imem_we",   64'(imem_we[0]),   64'd0);
        chk("midreset cpu_reset", 64'(cpu_reset[0]), 64'd1);
        chk("midreset rx_ready",  64'(rx_ready[0]),  64'd0);
        chk("midreset imem_addr", 64'(imem_addr[0]), 64'd0);
        chk("midreset drained",   64'(exp_q0.size()), 64'd0);
        repeat (3) @(negedge clk);
        reset[0] = 1'b0;
        // Reload after reset.
        load_list(t1);
        run_image(0, 0);
        // Length boundaries on DEPTH=256.
        build_random(256, 1'b0);
        run_image(0, 2);
        load_list('{8'h01, 8'h01});
        run_image(0, 0);
        // DEPTH=4, BASE=0x400: oversize, full, and zero-length.
        load_list('{8'h00, 8'h05});
        run_image(1, 0);
        build_random(4, 1'b0);
        run_image(1, 2);
        load_list('{8'h00, 8'h00, 8'h00});
        run_image(1, 0);
        // Randomized images on both instances.
        for (int r = 0; r < 12; r++) begin
            build_random($urandom_range(0, 8), ($urandom_range(0, 3) == 0));
            run_image(0, 2);
            build_random($urandom_range(0, 5), ($urandom_range(0, 3) == 0));
            run_image(1, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
